// File: rtl/input_pkg.sv
// Shared constants for the board input conditioner: default switch width,
// debounce lengths for hardware and for short benches, and button polarity.
package input_pkg;

    localparam int SW_WIDTH_DEFAULT        = 8;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;
    localparam int DEBOUNCE_SIM            = 4;
    localparam int BTN_ACTIVE_LOW_DEFAULT  = 1;

    // Width of a counter that must hold values 0 .. cycles-1, never less than one bit.
    function automatic int cnt_width(input int cycles);
        int w;
        w = $clog2(cycles);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced channel: a two-flop synchroniser, a delay flop used to see
// whether the synchronised value moved this cycle, a stability counter and
// the clean output register. A multi-bit channel is debounced as a whole
// vector, so any bit changing restarts the count.
module debounce_channel
    import input_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_raw,
    output logic [WIDTH-1:0] o_out,
    output logic             o_update
);

    localparam int              CW      = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_s2_d;
    logic [WIDTH-1:0] r_out;
    logic [CW-1:0]    r_cnt;
    logic             w_hold;
    logic             w_update;

    // Bring the raw pins into the clock domain and keep last cycle's value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_s2_d <= '0;
        end else begin
            r_s1   <= i_raw;
            r_s2   <= r_s1;
            r_s2_d <= r_s2;
        end
    end

    // Count is held at zero when the input matches the output or is still moving.
    always_comb begin
        w_hold   = (r_s2 == r_out) || (r_s2 != r_s2_d);
        w_update = !w_hold && (r_cnt == CNT_MAX);
    end

    // Advance the stability counter and commit the new value once it has lasted long enough.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_out <= '0;
        end else if (w_hold) begin
            r_cnt <= '0;
        end else if (w_update) begin
            r_out <= r_s2;
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_out    = r_out;
    assign o_update = w_update;

endmodule

// File: rtl/input_conditioner.sv
// Front end between the board pins and the load controller: synchronises and
// debounces both switch banks and the load button, and produces a one-cycle
// strobe when the debounced button goes from released to pressed.
module input_conditioner
    import input_pkg::*;
#(
    parameter int SW_WIDTH        = SW_WIDTH_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int BTN_ACTIVE_LOW  = BTN_ACTIVE_LOW_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [SW_WIDTH-1:0] sw_a_raw,
    input  logic [SW_WIDTH-1:0] sw_b_raw,
    input  logic                btn_raw,
    output logic [SW_WIDTH-1:0] sw_a,
    output logic [SW_WIDTH-1:0] sw_b,
    output logic                btn_load,
    output logic                btn_press
);

    logic [0:0] w_btn_in;
    logic [0:0] w_btn_out;
    logic       w_btn_update;
    logic       w_a_update;
    logic       w_b_update;
    logic       r_btn_press;

    // Normalise the button so everything downstream sees 1 = pressed.
    always_comb begin
        w_btn_in[0] = (BTN_ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;
    end

    debounce_channel #(
        .WIDTH           (SW_WIDTH),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_chan_a (
        .clk      (clk),
        .reset    (reset),
        .i_raw    (sw_a_raw),
        .o_out    (sw_a),
        .o_update (w_a_update)
    );

    debounce_channel #(
        .WIDTH           (SW_WIDTH),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_chan_b (
        .clk      (clk),
        .reset    (reset),
        .i_raw    (sw_b_raw),
        .o_out    (sw_b),
        .o_update (w_b_update)
    );

    debounce_channel #(
        .WIDTH           (1),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_chan_btn (
        .clk      (clk),
        .reset    (reset),
        .i_raw    (w_btn_in),
        .o_out    (w_btn_out),
        .o_update (w_btn_update)
    );

    // An update while the button reads released is a press; register it so the strobe lines up with btn_load rising.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_btn_press <= 1'b0;
        end else begin
            r_btn_press <= w_btn_update && !w_btn_out[0];
        end
    end

    assign btn_load  = w_btn_out[0];
    assign btn_press = r_btn_press;

    // The switch-bank update flags are not needed outside their channels.
    logic w_unused;
    assign w_unused = w_a_update ^ w_b_update;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with a short debounce length.
// Inputs change 1 ns after a rising edge, so a change is stable before the
// next edge N; the outputs are expected to move after edge N+6.
module tb_input_conditioner;
    import input_pkg::*;

    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic [W-1:0] sw_a_raw;
    logic [W-1:0] sw_b_raw;
    logic         btn_raw;
    logic [W-1:0] sw_a;
    logic [W-1:0] sw_b;
    logic         btn_load;
    logic         btn_press;

    int testsRun;
    int testsFailed;

    input_conditioner #(
        .SW_WIDTH        (W),
        .DEBOUNCE_CYCLES (DEBOUNCE_SIM),
        .BTN_ACTIVE_LOW  (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sw_a_raw  (sw_a_raw),
        .sw_b_raw  (sw_b_raw),
        .btn_raw   (btn_raw),
        .sw_a      (sw_a),
        .sw_b      (sw_b),
        .btn_load  (btn_load),
        .btn_press (btn_press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and sample shortly after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset with idle inputs (switches low, button released).
    task automatic applyReset();
        reset    = 1'b1;
        sw_a_raw = '0;
        sw_b_raw = '0;
        btn_raw  = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        btn_raw  = 1'b0;
        sw_a_raw = 8'hFF;
        sw_b_raw = 8'h00;
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        testsRun++;
        if (sw_a !== 8'h00 || btn_load !== 1'b0 || btn_press !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_outputs: got sw_a=%h load=%b press=%b expected 00 0 0", sw_a, btn_load, btn_press);
        end
        reset = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            testsRun++;
            if (sw_a !== 8'h00 || btn_load !== 1'b0 || btn_press !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL reset_hold_edge%0d: got sw_a=%h load=%b press=%b expected 00 0 0", k, sw_a, btn_load, btn_press);
            end
        end
        tick();
        testsRun++;
        if (sw_a !== 8'hFF || btn_load !== 1'b1 || btn_press !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL reset_release_update: got sw_a=%h load=%b press=%b expected FF 1 1", sw_a, btn_load, btn_press);
        end
        tick();
        testsRun++;
        if (btn_load !== 1'b1 || btn_press !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_strobe_single: got load=%b press=%b expected 1 0", btn_load, btn_press);
        end
    endtask

    task automatic test_switch_change();
        applyReset();
        sw_a_raw = 8'h5A;
        for (int k = 1; k <= 6; k++) begin
            tick();
            testsRun++;
            if (sw_a !== 8'h00 || sw_b !== 8'h00) begin
                testsFailed++;
                $display("[TB] FAIL switch_early_edge%0d: got sw_a=%h sw_b=%h expected 00 00", k, sw_a, sw_b);
            end
        end
        tick();
        testsRun++;
        if (sw_a !== 8'h5A || sw_b !== 8'h00) begin
            testsFailed++;
            $display("[TB] FAIL switch_update: got sw_a=%h sw_b=%h expected 5a 00", sw_a, sw_b);
        end
    endtask

    task automatic test_bounce();
        logic sawLoad;
        logic sawPress;
        sawLoad  = 1'b0;
        sawPress = 1'b0;
        applyReset();
        for (int i = 0; i < 20; i++) begin
            btn_raw = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
            tick();
            sawLoad  = sawLoad  | btn_load;
            sawPress = sawPress | btn_press;
        end
        btn_raw = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            sawLoad  = sawLoad  | btn_load;
            sawPress = sawPress | btn_press;
        end
        testsRun++;
        if (sawLoad !== 1'b0 || sawPress !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL bounce_reject: got sawLoad=%b sawPress=%b expected 0 0", sawLoad, sawPress);
        end
    endtask

    task automatic test_press_hold();
        int presses;
        logic dropped;
        presses = 0;
        dropped = 1'b0;
        applyReset();
        btn_raw = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            presses += int'(btn_press);
            testsRun++;
            if (btn_load !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL press_early_edge%0d: got load=%b expected 0", k, btn_load);
            end
        end
        tick();
        presses += int'(btn_press);
        testsRun++;
        if (btn_load !== 1'b1 || btn_press !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL press_rise: got load=%b press=%b expected 1 1", btn_load, btn_press);
        end
        for (int k = 8; k <= 100; k++) begin
            tick();
            presses += int'(btn_press);
            if (btn_load !== 1'b1) dropped = 1'b1;
        end
        testsRun++;
        if (presses !== 1 || dropped !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL press_held: got strobes=%0d dropped=%b expected 1 0", presses, dropped);
        end
        btn_raw = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            testsRun++;
            if (btn_load !== 1'b1 || btn_press !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL release_early_edge%0d: got load=%b press=%b expected 1 0", k, btn_load, btn_press);
            end
        end
        tick();
        testsRun++;
        if (btn_load !== 1'b0 || btn_press !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL release_fall: got load=%b press=%b expected 0 0", btn_load, btn_press);
        end
        tick();
        testsRun++;
        if (btn_press !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL release_no_strobe: got press=%b expected 0", btn_press);
        end
    endtask

    task automatic test_vector_restart();
        applyReset();
        sw_b_raw = 8'h0F;
        tick();
        tick();
        sw_b_raw = 8'h1F;
        for (int k = 1; k <= 6; k++) begin
            tick();
            testsRun++;
            if (sw_b !== 8'h00) begin
                testsFailed++;
                $display("[TB] FAIL restart_early_edge%0d: got sw_b=%h expected 00", k, sw_b);
            end
        end
        tick();
        testsRun++;
        if (sw_b !== 8'h1F) begin
            testsFailed++;
            $display("[TB] FAIL restart_update: got sw_b=%h expected 1f", sw_b);
        end
    endtask

    task automatic test_reset_mid_count();
        applyReset();
        sw_a_raw = 8'h33;
        for (int k = 0; k < 4; k++) begin
            tick();
        end
        reset = 1'b1;
        #1;
        testsRun++;
        if (sw_a !== 8'h00) begin
            testsFailed++;
            $display("[TB] FAIL midreset_during: got sw_a=%h expected 00", sw_a);
        end
        tick();
        reset = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            testsRun++;
            if (sw_a !== 8'h00) begin
                testsFailed++;
                $display("[TB] FAIL midreset_early_edge%0d: got sw_a=%h expected 00", k, sw_a);
            end
        end
        tick();
        testsRun++;
        if (sw_a !== 8'h33) begin
            testsFailed++;
            $display("[TB] FAIL midreset_update: got sw_a=%h expected 33", sw_a);
        end
    endtask

    task automatic test_simultaneous();
        applyReset();
        sw_a_raw = 8'hA5;
        sw_b_raw = 8'h3C;
        btn_raw  = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
        end
        testsRun++;
        if (sw_a !== 8'h00 || sw_b !== 8'h00 || btn_load !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL simul_before: got %h %h %b expected 00 00 0", sw_a, sw_b, btn_load);
        end
        tick();
        testsRun++;
        if (sw_a !== 8'hA5 || sw_b !== 8'h3C || btn_load !== 1'b1 || btn_press !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL simul_update: got %h %h %b %b expected a5 3c 1 1", sw_a, sw_b, btn_load, btn_press);
        end
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        reset       = 1'b1;
        sw_a_raw    = '0;
        sw_b_raw    = '0;
        btn_raw     = 1'b1;
        test_reset();
        test_switch_change();
        test_bounce();
        test_press_hold();
        test_vector_restart();
        test_reset_mid_count();
        test_simultaneous();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
